input_irq_ctrl: RTL and testbench

INPUT_IRQ_CTRL -- requirements
Module: input_irq_ctrl

---
 rtl/input_irq_ctrl_pkg.sv | 13 +
 rtl/input_debounce_ch.sv | 91 +++++++++
 rtl/input_irq_ctrl.sv | 119 +++++++++++
 tb/tb_input_irq_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/input_irq_ctrl_pkg.sv
// Shared constants for the input interrupt controller: bus width and
// Avalon word offsets of the register file.
package input_irq_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_CAPTURE = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;

endpackage

// File: rtl/input_debounce_ch.sv
// One input channel: multi-flop synchroniser, counter debounce and
// single-cycle rise/fall pulses of the debounced (stable) level.
module input_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic                   stable_s;
  logic                   rise_r;
  logic                   fall_r;

  // synchroniser shift chain, din enters at bit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      logic prev_r;

      assign stable_s = sync_s;

      // edge pulses from the previous synchronised level
      always_ff @(posedge clk) begin
        if (reset) begin
          prev_r <= 1'b0;
          rise_r <= 1'b0;
          fall_r <= 1'b0;
        end else begin
          prev_r <= sync_s;
          rise_r <= sync_s & ~prev_r;
          fall_r <= ~sync_s & prev_r;
        end
      end
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
      localparam logic [CW-1:0] CNT_ONE = CW'(1);

      logic [CW-1:0] cnt_r;
      logic          level_r;

      assign stable_s = level_r;

      // count disagreeing cycles; the edge pulse is registered with the level update
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_r   <= '0;
          level_r <= 1'b0;
          rise_r  <= 1'b0;
          fall_r  <= 1'b0;
        end else begin
          rise_r <= 1'b0;
          fall_r <= 1'b0;
          if (sync_s != level_r) begin
            if (cnt_r == CNT_MAX) begin
              cnt_r   <= '0;
              level_r <= sync_s;
              rise_r  <= sync_s;
              fall_r  <= ~sync_s;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            cnt_r <= '0;
          end
        end
      end
    end
  endgenerate

  assign stable = stable_s;
  assign rise   = rise_r;
  assign fall   = fall_r;

endmodule

// File: rtl/input_irq_ctrl.sv
// Debounced switch/key inputs with per-channel edge capture, mask and a
// level interrupt, exposed through a small Avalon-MM register file.
module input_irq_ctrl
  import input_irq_ctrl_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  inputs,
  input  logic [2:0]        avl_address,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [DATA_W-1:0] avl_writedata,
  output logic [DATA_W-1:0] avl_readdata,
  output logic              avl_irq
);

  logic [WIDTH-1:0]  stable_s;
  logic [WIDTH-1:0]  rise_s;
  logic [WIDTH-1:0]  fall_s;
  logic [WIDTH-1:0]  wdata_s;
  logic [WIDTH-1:0]  mask_r;
  logic [WIDTH-1:0]  capture_r;
  logic [WIDTH-1:0]  rise_en_r;
  logic [WIDTH-1:0]  fall_en_r;
  logic [WIDTH-1:0]  set_s;
  logic [WIDTH-1:0]  clr_s;
  logic [WIDTH-1:0]  capture_next_s;
  logic [WIDTH-1:0]  rd_word_s;
  logic [DATA_W-1:0] rd_ext_s;
  logic [DATA_W-1:0] readdata_r;
  logic              irq_r;
  logic              wr_mask_s;
  logic              wr_capture_s;
  logic              wr_rise_en_s;
  logic              wr_fall_en_s;
  logic              unused_wdata_s;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      input_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
      ) u_ch (
        .clk    (clk),
        .reset  (reset),
        .din    (inputs[g]),
        .stable (stable_s[g]),
        .rise   (rise_s[g]),
        .fall   (fall_s[g])
      );
    end
  endgenerate

  assign wdata_s        = avl_writedata[WIDTH-1:0];
  assign unused_wdata_s = ^avl_writedata;
  assign wr_mask_s      = avl_write && (avl_address == ADDR_MASK);
  assign wr_capture_s   = avl_write && (avl_address == ADDR_CAPTURE);
  assign wr_rise_en_s   = avl_write && (avl_address == ADDR_RISE_EN);
  assign wr_fall_en_s   = avl_write && (avl_address == ADDR_FALL_EN);

  // capture update: new set events override a simultaneous W1C
  always_comb begin
    set_s = (rise_s & rise_en_r) | (fall_s & fall_en_r);
    if (wr_capture_s) begin
      clr_s = wdata_s;
    end else begin
      clr_s = '0;
    end
    capture_next_s = (capture_r & ~clr_s) | set_s;
  end

  // control and capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_r    <= '0;
      capture_r <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
    end else begin
      capture_r <= capture_next_s;
      if (wr_mask_s)    mask_r    <= wdata_s;
      if (wr_rise_en_s) rise_en_r <= wdata_s;
      if (wr_fall_en_s) fall_en_r <= wdata_s;
    end
  end

  // read mux from current register state, so a same-cycle write is not visible
  always_comb begin
    case (avl_address)
      ADDR_DATA:    rd_word_s = stable_s;
      ADDR_MASK:    rd_word_s = mask_r;
      ADDR_CAPTURE: rd_word_s = capture_r;
      ADDR_RISE_EN: rd_word_s = rise_en_r;
      ADDR_FALL_EN: rd_word_s = fall_en_r;
      default:      rd_word_s = '0;
    endcase
    rd_ext_s              = '0;
    rd_ext_s[WIDTH-1:0]   = rd_word_s;
  end

  // read data holds between reads; interrupt follows masked capture
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r <= '0;
      irq_r      <= 1'b0;
    end else begin
      if (avl_read) readdata_r <= rd_ext_s;
      irq_r <= |(capture_r & mask_r);
    end
  end

  assign avl_readdata = readdata_r;
  assign avl_irq      = irq_r;

endmodule

// File: tb/tb_input_irq_ctrl.sv
// Directed self-checking bench for input_irq_ctrl (WIDTH=8, DEBOUNCE_CYCLES=4).
module tb_input_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  inputs;
  logic [2:0]  avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [31:0] avl_readdata;
  logic        avl_irq;

  int n_checks;
  int n_fail;

  input_irq_ctrl #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inputs        (inputs),
    .avl_address   (avl_address),
    .avl_read      (avl_read),
    .avl_write     (avl_write),
    .avl_writedata (avl_writedata),
    .avl_readdata  (avl_readdata),
    .avl_irq       (avl_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
    avl_address   = addr;
    avl_writedata = data;
    avl_write     = 1'b1;
    @(negedge clk);
    avl_write     = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] addr, output logic [31:0] data);
    avl_address = addr;
    avl_read    = 1'b1;
    @(negedge clk);
    avl_read    = 1'b0;
    data        = avl_readdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    inputs        = 8'h00;
    avl_address   = 3'd0;
    avl_read      = 1'b0;
    avl_write     = 1'b0;
    avl_writedata = 32'h0000_0000;
    cycles(3);
    reset = 1'b0;

    // reset state
    check_eq("rst_readdata", avl_readdata, 32'h0);
    check_eq("rst_irq", {31'h0, avl_irq}, 32'h0);
    read_check("rst_data", 3'd0, 32'h0);
    read_check("rst_mask", 3'd1, 32'h0);
    read_check("rst_capture", 3'd2, 32'h0);
    read_check("rst_rise_en", 3'd3, 32'h0);
    read_check("rst_fall_en", 3'd4, 32'h0);

    // rising edge on bit 0: irq exactly 2+4+2 cycles after the input change
    reg_write(3'd3, 32'h01);
    reg_write(3'd1, 32'h01);
    inputs = 8'h01;
    cycles(7);
    check_eq("rise_irq_early", {31'h0, avl_irq}, 32'h0);
    cycles(1);
    check_eq("rise_irq", {31'h0, avl_irq}, 32'h1);
    read_check("rise_capture", 3'd2, 32'h01);
    read_check("rise_data", 3'd0, 32'h01);

    // falling bit 0 with FALL_EN clear: data drops, capture kept
    inputs = 8'h00;
    cycles(10);
    read_check("fall_data", 3'd0, 32'h00);
    read_check("fall_capture", 3'd2, 32'h01);

    // 3-cycle glitch is rejected
    inputs = 8'h01;
    cycles(3);
    inputs = 8'h00;
    cycles(10);
    read_check("glitch_data", 3'd0, 32'h00);
    read_check("glitch_capture", 3'd2, 32'h01);
    check_eq("glitch_irq", {31'h0, avl_irq}, 32'h1);

    // W1C in the same cycle as a new rise pulse on bit 0: set wins
    inputs = 8'h01;
    cycles(6);
    reg_write(3'd2, 32'h01);
    read_check("setwins_capture", 3'd2, 32'h01);
    reg_write(3'd2, 32'h01);
    check_eq("w1c_irq_lag", {31'h0, avl_irq}, 32'h1);
    cycles(1);
    check_eq("w1c_irq", {31'h0, avl_irq}, 32'h0);
    read_check("w1c_capture", 3'd2, 32'h00);

    // falling edge on bit 7 captured while masked
    reg_write(3'd1, 32'h00);
    reg_write(3'd4, 32'h80);
    inputs = 8'h81;
    cycles(10);
    inputs = 8'h01;
    cycles(10);
    read_check("fall7_capture", 3'd2, 32'h80);
    check_eq("fall7_irq_masked", {31'h0, avl_irq}, 32'h0);
    reg_write(3'd1, 32'h80);
    check_eq("mask_irq_lag", {31'h0, avl_irq}, 32'h0);
    cycles(1);
    check_eq("mask_irq", {31'h0, avl_irq}, 32'h1);

    // unused addresses, width truncation, read-during-write
    read_check("addr6", 3'd6, 32'h0);
    reg_write(3'd5, 32'hFFFF_FFFF);
    read_check("addr5", 3'd5, 32'h0);
    read_check("mask_kept", 3'd1, 32'h80);
    reg_write(3'd1, 32'hFFFF_FFFF);
    read_check("mask_trunc", 3'd1, 32'hFF);
    avl_address   = 3'd1;
    avl_writedata = 32'h5A;
    avl_read      = 1'b1;
    avl_write     = 1'b1;
    @(negedge clk);
    avl_read      = 1'b0;
    avl_write     = 1'b0;
    check_eq("rdwr_old", avl_readdata, 32'hFF);
    read_check("rdwr_new", 3'd1, 32'h5A);
    read_check("data_bit0", 3'd0, 32'h01);

    // reset in the middle of debouncing a rise on bit 2
    reg_write(3'd3, 32'h04);
    inputs = 8'h05;
    cycles(3);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    check_eq("mid_rst_readdata", avl_readdata, 32'h0);
    check_eq("mid_rst_irq", {31'h0, avl_irq}, 32'h0);
    read_check("mid_rst_data", 3'd0, 32'h0);
    read_check("mid_rst_mask", 3'd1, 32'h0);
    read_check("mid_rst_capture", 3'd2, 32'h0);
    read_check("mid_rst_rise_en", 3'd3, 32'h0);
    read_check("mid_rst_fall_en", 3'd4, 32'h0);
    cycles(20);
    read_check("post_rst_data", 3'd0, 32'h05);
    read_check("post_rst_capture", 3'd2, 32'h0);
    check_eq("post_rst_irq", {31'h0, avl_irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
